muldiv_unit: RTL
================

# muldiv_unit

Execute-stage HI/LO unit consuming the `FUNCT` code produced by ID-stage function generation for `OP_SPECIAL` instructions. It performs MULT/MULTU in one cycle and DIV/DIVU iteratively over `WIDTH` cycles, owns the HI/LO architectural registers, and services MFHI/MFLO/MTHI/MTLO. It raises a stall request to the pipeline controller while a divide is in flight.

## Interface
- `WIDTH`, 32, operand/HI/LO width; divide iteration count equals `WIDTH`.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-low reset.
- `en`  input  1  EX holds a valid `OP_SPECIAL` instruction this cycle.
- `funct`  input  6  funct code; decoded values: MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B; all others ignored.
- `operand_1`  input  WIDTH  rs value (dividend / multiplicand / MTHI-MTLO source).
- `operand_2`  input  WIDTH  rt value (divisor / multiplier).
- `flush`  input  1  pipeline flush; aborts an in-flight divide.
- `stall_req`  output  1  hold IF..EX this cycle.
- `result`  output  WIDTH  MFHI→`hi`, MFLO→`lo`, else 0.
- `hi`, `lo`  output  WIDTH  current HI/LO register contents.

## Operation
- States: IDLE, DIV, DONE. Reset: state IDLE, `hi`=`lo`=0, counter 0, `stall_req`=0, `result`=0.
- IDLE, `en`=1:
  - MULT/MULTU: signed/unsigned 2·WIDTH product written at the clock edge; `hi`=upper half, `lo`=lower half. No stall.
  - MTHI/MTLO: `hi`/`lo` ← `operand_1` at the edge.
  - MFHI/MFLO: `result` combinational from the current register.
  - DIV/DIVU with `operand_2`≠0: latch magnitudes and signs, clear counter, go to DIV. `stall_req`=1 combinationally in this accept cycle.
  - DIV/DIVU with `operand_2`=0: no-op. `hi`/`lo` unchanged, no stall, stays IDLE.
- DIV state:
  - Restoring division, one quotient bit per cycle; counter increments.
  - `stall_req`=1 throughout.
  - On the edge where counter reaches WIDTH−1: write `lo`=quotient and `hi`=remainder, go to DONE.
  - DIV sign rules: quotient negated if operand signs differ; remainder takes the dividend's sign. Magnitude of 0x80000000 is handled as unsigned 2^31.
- DONE: `stall_req`=0 and new accepts are suppressed (the same DIV still sits in EX). Unconditionally returns to IDLE next edge.
- `flush`=1 in DIV or DONE: next state IDLE; `hi`/`lo` keep pre-divide values. In IDLE, `flush` suppresses every write that cycle.
- Asynchronous `rst` low at any time: immediate return to reset values, including mid-divide.

## Timing
- MULT/MTHI/MTLO: results visible on `hi`/`lo` in the cycle after issue; a back-to-back MFHI/MFLO reads the new value with no forwarding needed.
- DIV/DIVU: `stall_req` high for 1 + WIDTH cycles (33 at default), then DONE for 1 cycle with `stall_req` low. The next instruction enters EX in the cycle after DONE.
- `stall_req` is combinational from state, `en`, `funct` and `operand_2`. All register updates occur on rising `clk`.
- A DIV/DIVU arriving in the cycle after DONE is accepted normally.

## Configuration
- `MULDIV_DIV_EN` defined:
  - DIV/DIVU supported as above.
- `MULDIV_DIV_EN` undefined:
  - Divider datapath, counter and DIV/DONE states are compiled out.
  - DIV/DIVU behave like the zero-divisor case: no-op, `hi`/`lo` unchanged, `stall_req` constantly 0.
  - MULT/MULTU/MFxx/MTxx are unaffected.

## Test plan
- MULT 0xFFFFFFFE×0x3 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA after one edge, `stall_req` never high. MULTU with the same operands → `hi`=0x00000002, `lo`=0xFFFFFFFA.
- DIVU 100/7 held in EX → `stall_req` high exactly 33 cycles, then low for DONE. `lo`=14, `hi`=2. The next DIVU 9/3 accepted afterwards → `lo`=3, `hi`=0.
- DIV 0xFFFFFFF9(−7)/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- DIV 5/0 with `hi`=0xA, `lo`=0xB → no stall, `hi`/`lo` stay 0xA/0xB.
- Flush case: `flush` pulsed at DIV cycle 10 → state IDLE, `stall_req` 0 next cycle, `hi`/`lo` unchanged. Reset case: `rst` low at DIV cycle 20 → `hi`=`lo`=0, `stall_req`=0 immediately.
- MTHI 0x12345678 then MFHI next cycle → `result`=0x12345678. With `MULDIV_DIV_EN` undefined, DIVU 100/7 → `stall_req` 0, `hi`/`lo` unchanged.

Source files
------------

// File: rtl/muldiv_unit.sv
// HI/LO execute-stage unit: single-cycle MULT/MULTU, MFxx/MTxx, and an iterative
// restoring divider (one quotient bit per cycle) enabled by defining MULDIV_DIV_EN.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] operand_1,
    input  logic [WIDTH-1:0] operand_2,
    input  logic             flush,
    output logic             stall_req,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;

    logic                   wr_ok;
    logic                   is_mult;
    logic signed [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0]     prod_u;
    logic [2*WIDTH-1:0]     prod;

    assign is_mult = (funct == F_MULT) || (funct == F_MULTU);
    assign prod_s  = $signed({{WIDTH{operand_1[WIDTH-1]}}, operand_1}) *
                     $signed({{WIDTH{operand_2[WIDTH-1]}}, operand_2});
    assign prod_u  = {{WIDTH{1'b0}}, operand_1} * {{WIDTH{1'b0}}, operand_2};
    assign prod    = (funct == F_MULT) ? prod_s : prod_u;

`ifdef MULDIV_DIV_EN
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam int         CW      = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem, quot, dvs;
    logic             neg_q, neg_r;
    logic             is_div, div_signed, div_req, div_acc, div_last;
    logic [WIDTH-1:0] mag1, mag2, rem_nxt, quot_nxt, q_fin, r_fin;
    logic [WIDTH:0]   rem_sh;
    logic             q_bit;

    assign is_div     = (funct == F_DIV) || (funct == F_DIVU);
    assign div_signed = (funct == F_DIV);
    // Magnitudes are unsigned, so the most negative dividend maps to 2^(WIDTH-1).
    assign mag1       = (div_signed && operand_1[WIDTH-1]) ? -operand_1 : operand_1;
    assign mag2       = (div_signed && operand_2[WIDTH-1]) ? -operand_2 : operand_2;
    assign div_req    = en && is_div && (operand_2 != '0);
    assign div_acc    = div_req && !flush && (state == S_IDLE);
    assign div_last   = (state == S_DIV) && (cnt == CW'(WIDTH-1)) && !flush;
    assign wr_ok      = en && !flush && (state == S_IDLE);
    assign stall_req  = rst && ((state == S_DIV) || ((state == S_IDLE) && div_req));

    always_comb begin
        rem_sh   = {rem, quot[WIDTH-1]};
        q_bit    = (rem_sh >= {1'b0, dvs});
        // Partial remainder stays below the divisor, so the low WIDTH bits suffice.
        rem_nxt  = q_bit ? (rem_sh[WIDTH-1:0] - dvs) : rem_sh[WIDTH-1:0];
        quot_nxt = {quot[WIDTH-2:0], q_bit};
        q_fin    = neg_q ? -quot_nxt : quot_nxt;
        r_fin    = neg_r ? -rem_nxt : rem_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (div_acc) state_nxt = S_DIV;
            S_DIV:   if (flush) state_nxt = S_IDLE;
                     else if (cnt == CW'(WIDTH-1)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            rem   <= '0;
            quot  <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            state <= state_nxt;
            if (div_acc) begin
                cnt   <= '0;
                rem   <= '0;
                quot  <= mag1;
                dvs   <= mag2;
                neg_q <= div_signed && (operand_1[WIDTH-1] ^ operand_2[WIDTH-1]);
                neg_r <= div_signed && operand_1[WIDTH-1];
            end else if (state == S_DIV) begin
                cnt  <= cnt + 1'b1;
                rem  <= rem_nxt;
                quot <= quot_nxt;
            end
        end
    end
`else
    assign wr_ok     = en && !flush;
    assign stall_req = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi <= '0;
            lo <= '0;
        end else if (wr_ok && is_mult) begin
            hi <= prod[2*WIDTH-1:WIDTH];
            lo <= prod[WIDTH-1:0];
        end else if (wr_ok && funct == F_MTHI) begin
            hi <= operand_1;
        end else if (wr_ok && funct == F_MTLO) begin
            lo <= operand_1;
`ifdef MULDIV_DIV_EN
        end else if (div_last) begin
            lo <= q_fin;
            hi <= r_fin;
`endif
        end
    end

    always_comb begin
        result = '0;
        if (rst && en && funct == F_MFHI) result = hi;
        else if (rst && en && funct == F_MFLO) result = lo;
    end
endmodule
